// File: rtl/time_bcd_formatter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : time_bcd_formatter                                               |
// | Purpose  : Converts binary hh:mm:ss into six BCD digits for the HEX0..HEX5 |
// |            seven-segment decoders. The engine is a multi-cycle double      |
// |            dabble. A blink mask flashes the field being edited.            |
// | Ports    : CLOCK_50, reset (async, active high)                            |
// |            load, sec_in[5:0], min_in[5:0], hr_in[4:0]  - conversion request|
// |            blank_sel[1:0], blink_tick                  - blink control     |
// |            busy, done, range_err                       - status            |
// |            sec/min/hr _ones/_tens[3:0]                 - committed digits  |
// |            blank_mask[5:0] (bit0 = sec_ones .. bit5 = hr_tens)             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module time_bcd_formatter #(
  parameter int BLINK_DIV = 1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       load,
  input  logic [5:0] sec_in,
  input  logic [5:0] min_in,
  input  logic [4:0] hr_in,
  input  logic [1:0] blank_sel,
  input  logic       blink_tick,
  output logic       busy,
  output logic       done,
  output logic       range_err,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] hr_tens,
  output logic [5:0] blank_mask
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [3:0] BLINK_DIV_C = 4'(BLINK_DIV);
  localparam logic [2:0] LAST_ITER   = 3'd5;

  // Conversion engine state
  state_t      state_q;
  logic [2:0]  iter_q;
  logic        pending_q;
  logic        busy_q;
  logic        done_q;
  logic        range_err_q;
  logic        range_cap_q;
  logic [5:0]  sec_bin_q, min_bin_q, hr_bin_q;
  logic [7:0]  sec_bcd_q, min_bcd_q, hr_bcd_q;
  logic [23:0] digits_q;

  logic [13:0] sec_step_d, min_step_d, hr_step_d;
  logic        capture_d;

  // Blink state
  logic [1:0]  sel_q;
  logic [3:0]  blink_cnt_q;
  logic [3:0]  blink_cnt_inc_d;
  logic        blink_phase_q;
  logic [5:0]  mask_q;
  logic [5:0]  field_mask_d;

  // One double-dabble iteration: correct every BCD nibble that would overflow
  // past 9 when doubled, then shift the {bcd, binary} pair left by one.
  function automatic logic [13:0] dabble_step(input logic [7:0] bcd,
                                              input logic [5:0] bin);
    logic [7:0]  adj;
    logic [13:0] pair;
    adj = bcd;
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
    pair = {adj, bin};
    return pair << 1;
  endfunction

  always_comb begin
    sec_step_d = dabble_step(sec_bcd_q, sec_bin_q);
    min_step_d = dabble_step(min_bcd_q, min_bin_q);
    hr_step_d  = dabble_step(hr_bcd_q,  hr_bin_q);
  end

  // A fresh sample is taken either on a request in IDLE, or at the commit edge
  // when a request arrived during the conversion (or arrives right now).
  always_comb begin
    capture_d = ((state_q == ST_IDLE) && load) ||
                ((state_q == ST_COMMIT) && (pending_q || load));
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      iter_q      <= 3'd0;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
      range_cap_q <= 1'b0;
      sec_bin_q   <= 6'd0;
      min_bin_q   <= 6'd0;
      hr_bin_q    <= 6'd0;
      sec_bcd_q   <= 8'd0;
      min_bcd_q   <= 8'd0;
      hr_bcd_q    <= 8'd0;
      digits_q    <= 24'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: ;
        ST_SHIFT: begin
          {sec_bcd_q, sec_bin_q} <= sec_step_d;
          {min_bcd_q, min_bin_q} <= min_step_d;
          {hr_bcd_q,  hr_bin_q}  <= hr_step_d;
          iter_q <= iter_q + 3'd1;
          if (load) pending_q <= 1'b1;
          if (iter_q == LAST_ITER) state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          digits_q    <= {hr_bcd_q, min_bcd_q, sec_bcd_q};
          done_q      <= 1'b1;
          range_err_q <= range_cap_q;
          pending_q   <= 1'b0;
          if (!capture_d) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Capture overrides the per-state updates above (restart from COMMIT).
      if (capture_d) begin
        sec_bin_q   <= sec_in;
        min_bin_q   <= min_in;
        hr_bin_q    <= {1'b0, hr_in};
        sec_bcd_q   <= 8'd0;
        min_bcd_q   <= 8'd0;
        hr_bcd_q    <= 8'd0;
        iter_q      <= 3'd0;
        busy_q      <= 1'b1;
        state_q     <= ST_SHIFT;
        range_cap_q <= (sec_in > 6'd59) || (min_in > 6'd59) || (hr_in > 5'd23);
      end
    end
  end

  // Blink divider and mask
  always_comb begin
    blink_cnt_inc_d = blink_cnt_q + 4'd1;
    case (sel_q)
      2'b01:   field_mask_d = 6'b000011;
      2'b10:   field_mask_d = 6'b001100;
      2'b11:   field_mask_d = 6'b110000;
      default: field_mask_d = 6'b000000;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sel_q         <= 2'b00;
      blink_cnt_q   <= 4'd0;
      blink_phase_q <= 1'b0;
      mask_q        <= 6'd0;
    end else begin
      sel_q  <= blank_sel;
      mask_q <= blink_phase_q ? field_mask_d : 6'd0;
      // Switching fields restarts the blink cycle in the visible phase.
      if (blank_sel != sel_q) begin
        blink_phase_q <= 1'b0;
        blink_cnt_q   <= 4'd0;
      end else if (blink_tick) begin
        if (blink_cnt_inc_d == BLINK_DIV_C) begin
          blink_phase_q <= ~blink_phase_q;
          blink_cnt_q   <= 4'd0;
        end else begin
          blink_cnt_q <= blink_cnt_inc_d;
        end
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign range_err  = range_err_q;
  assign {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones} = digits_q;
  assign blank_mask = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_time_bcd_formatter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_time_bcd_formatter                                            |
// | Purpose  : Self-checking bench for time_bcd_formatter (two instances with  |
// |            different BLINK_DIV) against a behavioural model.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_time_bcd_formatter;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       load       = 1'b0;
  logic [5:0] sec_in     = 6'd0;
  logic [5:0] min_in     = 6'd0;
  logic [4:0] hr_in      = 5'd0;
  logic [1:0] blank_sel  = 2'd0;
  logic       blink_tick = 1'b0;

  logic       busy[2], done[2], rerr[2];
  logic [3:0] so[2], st[2], mo[2], mt[2], ho[2], ht[2];
  logic [5:0] mask[2];

  int n_checks = 0;
  int n_fail   = 0;
  int d_count  = 0;

  always #5 clk = ~clk;

  time_bcd_formatter #(.BLINK_DIV(1)) u_dut0 (
    .CLOCK_50(clk), .reset(reset), .load(load),
    .sec_in(sec_in), .min_in(min_in), .hr_in(hr_in),
    .blank_sel(blank_sel), .blink_tick(blink_tick),
    .busy(busy[0]), .done(done[0]), .range_err(rerr[0]),
    .sec_ones(so[0]), .sec_tens(st[0]), .min_ones(mo[0]), .min_tens(mt[0]),
    .hr_ones(ho[0]), .hr_tens(ht[0]), .blank_mask(mask[0])
  );

  time_bcd_formatter #(.BLINK_DIV(3)) u_dut1 (
    .CLOCK_50(clk), .reset(reset), .load(load),
    .sec_in(sec_in), .min_in(min_in), .hr_in(hr_in),
    .blank_sel(blank_sel), .blink_tick(blink_tick),
    .busy(busy[1]), .done(done[1]), .range_err(rerr[1]),
    .sec_ones(so[1]), .sec_tens(st[1]), .min_ones(mo[1]), .min_tens(mt[1]),
    .hr_ones(ho[1]), .hr_tens(ht[1]), .blank_mask(mask[1])
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dut_digits(input int k);
    return int'({8'd0, ht[k], ho[k], mt[k], mo[k], st[k], so[k]});
  endfunction

  // ---------------- behavioural model ----------------
  // m_left counts clock edges until the commit edge (0 = idle).
  int m_left = 0;
  bit m_pend = 0;
  int m_sec = 0, m_min = 0, m_hr = 0;
  int e_dig = 0;
  bit e_busy = 0, e_done = 0, e_rerr = 0;
  int b_sel[2]  = '{0, 0};
  int b_cnt[2]  = '{0, 0};
  bit b_ph[2]   = '{0, 0};
  int e_mask[2] = '{0, 0};
  int b_div[2]  = '{1, 3};

  function automatic int dec2(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  task automatic model_capture();
    m_sec  = int'(sec_in);
    m_min  = int'(min_in);
    m_hr   = int'(hr_in);
    m_left = 7;
    e_busy = 1;
  endtask

  // Each negedge: advance the model by the posedge that just happened (inputs
  // are only changed 1 ns after a negedge), then compare both instances.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      m_left = 0; m_pend = 0; e_dig = 0; e_busy = 0; e_done = 0; e_rerr = 0;
      for (int k = 0; k < 2; k++) begin
        b_sel[k] = 0; b_cnt[k] = 0; b_ph[k] = 0; e_mask[k] = 0;
      end
    end else begin
      e_done = 0;
      if (m_left == 0) begin
        if (load) model_capture();
      end else if (m_left == 1) begin
        e_dig  = dec2(m_hr) * 65536 + dec2(m_min) * 256 + dec2(m_sec);
        e_rerr = (m_sec > 59) || (m_min > 59) || (m_hr > 23);
        e_done = 1;
        if (m_pend || load) begin
          m_pend = 0;
          model_capture();
        end else begin
          m_left = 0;
          e_busy = 0;
        end
      end else begin
        if (load) m_pend = 1;
        m_left--;
      end
      for (int k = 0; k < 2; k++) begin
        e_mask[k] = (b_ph[k] && b_sel[k] != 0) ? (3 << (2 * (b_sel[k] - 1))) : 0;
        if (int'(blank_sel) != b_sel[k]) begin
          b_ph[k]  = 0;
          b_cnt[k] = 0;
        end else if (blink_tick) begin
          b_cnt[k]++;
          if (b_cnt[k] == b_div[k]) begin
            b_ph[k]  = !b_ph[k];
            b_cnt[k] = 0;
          end
        end
        b_sel[k] = int'(blank_sel);
      end
    end
    if (done[0]) d_count++;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("busy%0d", k),   int'(busy[k]), int'(e_busy));
      check($sformatf("done%0d", k),   int'(done[k]), int'(e_done));
      check($sformatf("rerr%0d", k),   int'(rerr[k]), int'(e_rerr));
      check($sformatf("digits%0d", k), dut_digits(k), e_dig);
      check($sformatf("mask%0d", k),   int'(mask[k]), e_mask[k]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_load(input int s, input int m, input int h);
    @(negedge clk); #1;
    sec_in = 6'(s); min_in = 6'(m); hr_in = 5'(h); load = 1'b1;
    @(negedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[0] && n < 40);
    if (!done[0]) check("done_timeout", 0, 1);
  endtask

  task automatic tick_pulse();
    @(negedge clk); #1; blink_tick = 1'b1;
    @(negedge clk); #1; blink_tick = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  int lat, cnt, d0;
  int vals_sm[6] = '{0, 9, 10, 59, 60, 63};
  int vals_h[6]  = '{0, 9, 10, 23, 24, 31};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_digits", dut_digits(0), 0);
    check("rst_busy",   int'(busy[0]), 0);
    check("rst_mask",   int'(mask[0]), 0);
    #1 reset = 1'b0;

    // 23:59:59, latency
    do_load(59, 59, 23);
    wait_done(lat);
    check("t1_latency", lat, 7);
    check("t1_digits", dut_digits(0), 32'h235959);
    check("t1_rerr", int'(rerr[0]), 0);

    // pending request sampled at commit edge
    do_load(7, 0, 0);
    @(negedge clk); @(negedge clk); #1;
    sec_in = 6'd8; load = 1'b1;
    @(negedge clk); #1; load = 1'b0;
    wait_done(lat);
    check("t2_first", dut_digits(0), 32'h000007);
    wait_done(lat);
    check("t2_gap", lat, 7);
    check("t2_second", dut_digits(0), 32'h000008);
    cnt = 0;
    repeat (20) begin @(negedge clk); if (done[0]) cnt++; end
    check("t2_no_third", cnt, 0);

    // out of range
    do_load(60, 63, 31);
    wait_done(lat);
    check("t3_digits", dut_digits(0), 32'h316360);
    check("t3_rerr", int'(rerr[0]), 1);
    do_load(45, 30, 12);
    wait_done(lat);
    check("t3b_digits", dut_digits(0), 32'h123045);
    check("t3b_rerr", int'(rerr[0]), 0);

    // blinking
    @(negedge clk); #1; blank_sel = 2'b10;
    repeat (3) @(negedge clk);
    tick_pulse(); @(negedge clk); check("t4_mask1", int'(mask[0]), 6'b001100);
    tick_pulse(); @(negedge clk); check("t4_mask2", int'(mask[0]), 6'b000000);
    tick_pulse(); @(negedge clk); check("t4_mask3", int'(mask[0]), 6'b001100);
    @(negedge clk); #1; blank_sel = 2'b11; blink_tick = 1'b1;
    @(negedge clk); #1; blink_tick = 1'b0;
    @(negedge clk); check("t4_sel_change", int'(mask[0]), 6'b000000);
    tick_pulse(); @(negedge clk); check("t4_mask_hr", int'(mask[0]), 6'b110000);
    @(negedge clk); #1; blank_sel = 2'b00;

    // reset mid-conversion
    do_load(9, 9, 9);
    wait_done(lat);
    check("t5_pre", dut_digits(0), 32'h090909);
    do_load(30, 20, 10);
    @(negedge clk); @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("t5_rst_digits", dut_digits(0), 0);
    check("t5_rst_busy", int'(busy[0]), 0);
    @(negedge clk); #1; reset = 1'b0;
    cnt = 0;
    repeat (15) begin @(negedge clk); if (done[0]) cnt++; end
    check("t5_no_done", cnt, 0);
    do_load(5, 4, 3);
    wait_done(lat);
    check("t5_after", dut_digits(0), 32'h030405);

    // corner sweep: one load per conversion, exactly one done each
    d0 = d_count;
    for (int a = 0; a < 6; a++)
      for (int b = 0; b < 6; b++)
        for (int c = 0; c < 6; c++) begin
          do_load(vals_sm[a], vals_sm[b], vals_h[c]);
          repeat (8) @(negedge clk);
        end
    check("sweep_done_count", d_count - d0, 216);

    // random traffic: loads at any time, ticks, field changes
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk); #1;
      sec_in     = 6'($urandom_range(0, 63));
      min_in     = 6'($urandom_range(0, 63));
      hr_in      = 5'($urandom_range(0, 31));
      load       = ($urandom_range(0, 9) == 0);
      blink_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 24) == 0) blank_sel = 2'($urandom_range(0, 3));
    end
    @(negedge clk); #1; load = 1'b0; blink_tick = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
